// File: rtl/wishbone_arbiter_if.sv
// ---------------------------------------------------------------------------
// wishbone_arbiter_if
// One point-to-point Wishbone link between an initiator and a target.
//   adr, wdat          : address / write data       (initiator -> target)
//   stb, cyc, we,
//   msk, sel           : strobe, cycle, write enable, mask, select
//                                                    (initiator -> target)
//   rdat               : read data                   (target -> initiator)
//   ack                : acknowledge                 (target -> initiator)
//   err                : one-cycle watchdog abort    (target -> initiator)
//   gnt                : initiator currently owns the shared bus
//                                                    (target -> initiator)
// Modports:
//   master : the initiator's view
//   slave  : the target's view
// The arbiter takes the slave view on each master-facing link and the
// master view on the link towards the slave. On that slave-side link,
// err and gnt have no producer and are tied off by whoever instantiates it.
// ---------------------------------------------------------------------------
interface wishbone_arbiter_if;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        stb;
  logic        cyc;
  logic        we;
  logic        msk;
  logic        sel;
  logic        ack;
  logic        err;
  logic        gnt;

  modport master (
    output adr, wdat, stb, cyc, we, msk, sel,
    input  rdat, ack, err, gnt
  );

  modport slave (
    input  adr, wdat, stb, cyc, we, msk, sel,
    output rdat, ack, err, gnt
  );
endinterface

// File: rtl/wishbone_arbiter.sv
// ---------------------------------------------------------------------------
// wishbone_arbiter
// Two-master / one-slave Wishbone arbiter.
// - Round-robin grant, held for the whole cyc.
// - Bus watchdog aborts transfers the slave never acknowledges.
//
// Ports:
//   clk : system clock, all state on the rising edge
//   rst : asynchronous, active-low reset
//   m0  : link to master 0 (host command master), slave view
//   m1  : link to master 1 (DMA / stream engine), slave view
//   s   : link to the shared slave, master view
//
// Parameters:
//   TIMEOUT  : number of consecutive stb cycles without ack before abort
//              (0 disables the watchdog)
//   TO_WIDTH : watchdog counter width; TIMEOUT must fit
// ---------------------------------------------------------------------------
module wishbone_arbiter #(
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned TO_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  wishbone_arbiter_if.slave  m0,
  wishbone_arbiter_if.slave  m1,
  wishbone_arbiter_if.master s
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GNT0   = 3'd1;
  localparam logic [2:0] GNT1   = 3'd2;
  localparam logic [2:0] ABORT0 = 3'd3;
  localparam logic [2:0] ABORT1 = 3'd4;

  // The watchdog fires on the stb cycle that would bring the count of
  // un-acked stb cycles up to TIMEOUT. The counter holds the cycles already
  // completed, so that cycle is the one where it reads TIMEOUT-1.
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

  logic [2:0]          state_q, state_d;
  logic                last_q, last_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;

  logic in_gnt0, in_gnt1, own0, own1;
  logic bus_stb;
  logic wd_fire;

  assign in_gnt0 = (state_q == GNT0);
  assign in_gnt1 = (state_q == GNT1);
  assign own0    = in_gnt0 || (state_q == ABORT0);
  assign own1    = in_gnt1 || (state_q == ABORT1);

  // Strobe the slave actually sees (forced low in ABORT/IDLE).
  assign bus_stb = (in_gnt0 & m0.stb) | (in_gnt1 & m1.stb);

  // An ack on the same cycle wins over the watchdog.
  assign wd_fire = (TIMEOUT != 0)
                && ((in_gnt0 && m0.cyc) || (in_gnt1 && m1.cyc))
                && bus_stb && !s.ack && (cnt_q == TO_LAST);

  // Next-state / round-robin logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m0.cyc && m1.cyc) state_d = last_q ? GNT0 : GNT1;
        else if (m0.cyc)      state_d = GNT0;
        else if (m1.cyc)      state_d = GNT1;
      end
      GNT0: begin
        // A cyc release hands straight over to a waiting master.
        if (!m0.cyc)     state_d = m1.cyc ? GNT1 : IDLE;
        else if (wd_fire) state_d = ABORT0;
      end
      GNT1: begin
        if (!m1.cyc)     state_d = m0.cyc ? GNT0 : IDLE;
        else if (wd_fire) state_d = ABORT1;
      end
      ABORT0: if (!m0.cyc) state_d = m1.cyc ? GNT1 : IDLE;
      ABORT1: if (!m1.cyc) state_d = m0.cyc ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase

    last_d = last_q;
    if (state_d == GNT0 && state_q != GNT0) last_d = 1'b0;
    if (state_d == GNT1 && state_q != GNT1) last_d = 1'b1;

    // Watchdog: cleared on any state change (covers entry into GNTn),
    // outside GNTn, while stb is low or on ack; otherwise saturating count.
    cnt_d = cnt_q;
    if ((state_d != state_q) || !(in_gnt0 || in_gnt1) || !bus_stb || s.ack)
      cnt_d = '0;
    else if (cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slave-side mux. During ABORTn the owner keeps address/data on the bus
  // but stb/cyc are held low so the slave sees no transfer.
  always_comb begin
    s.adr  = '0;
    s.wdat = '0;
    s.stb  = 1'b0;
    s.cyc  = 1'b0;
    s.we   = 1'b0;
    s.msk  = 1'b0;
    s.sel  = 1'b0;
    if (own0) begin
      s.adr  = m0.adr;
      s.wdat = m0.wdat;
      s.stb  = in_gnt0 & m0.stb;
      s.cyc  = in_gnt0 & m0.cyc;
      s.we   = m0.we;
      s.msk  = m0.msk;
      s.sel  = m0.sel;
    end else if (own1) begin
      s.adr  = m1.adr;
      s.wdat = m1.wdat;
      s.stb  = in_gnt1 & m1.stb;
      s.cyc  = in_gnt1 & m1.cyc;
      s.we   = m1.we;
      s.msk  = m1.msk;
      s.sel  = m1.sel;
    end
  end

  // Read data is broadcast; ack qualifies it for the owner only.
  assign m0.rdat = s.rdat;
  assign m1.rdat = s.rdat;
  assign m0.ack  = in_gnt0 & s.ack;
  assign m1.ack  = in_gnt1 & s.ack;
  assign m0.err  = in_gnt0 & wd_fire;
  assign m1.err  = in_gnt1 & wd_fire;
  assign m0.gnt  = own0;
  assign m1.gnt  = own1;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wishbone_arbiter
// Directed bench for wishbone_arbiter (TIMEOUT = 8). Inputs change on the
// falling edge; outputs are sampled 1 ns later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_wishbone_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wishbone_arbiter_if m0_if ();
  wishbone_arbiter_if m1_if ();
  wishbone_arbiter_if s_if ();

  wishbone_arbiter #(
    .TIMEOUT  (8),
    .TO_WIDTH (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_m0(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
    m0_if.cyc  = cyc;
    m0_if.stb  = stb;
    m0_if.we   = we;
    m0_if.adr  = adr;
    m0_if.wdat = dat;
  endtask

  task automatic set_m1(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
    m1_if.cyc  = cyc;
    m1_if.stb  = stb;
    m1_if.we   = we;
    m1_if.adr  = adr;
    m1_if.wdat = dat;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  int rem [2];
  int acks [2];

  initial begin
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    m0_if.msk = 1'b0; m0_if.sel = 1'b0;
    m1_if.msk = 1'b0; m1_if.sel = 1'b0;
    s_if.ack  = 1'b0;
    s_if.rdat = 32'h0;
    s_if.err  = 1'b0;
    s_if.gnt  = 1'b0;

    // ---------------- reset state ----------------
    step(); step(); #1;
    check_val("rst_s_stb",  {31'd0, s_if.stb},  32'd0);
    check_val("rst_s_cyc",  {31'd0, s_if.cyc},  32'd0);
    check_val("rst_s_adr",  s_if.adr,           32'd0);
    check_val("rst_m0_gnt", {31'd0, m0_if.gnt}, 32'd0);
    check_val("rst_m1_gnt", {31'd0, m1_if.gnt}, 32'd0);
    check_val("rst_m0_dat", m0_if.rdat,         32'd0);
    rst = 1'b1;
    $display("txn reset released");

    // ---------------- simultaneous request after reset ----------------
    step();
    set_m0(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    set_m1(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    step(); #1;
    check_val("sim_m0_gnt", {31'd0, m0_if.gnt}, 32'd1);
    check_val("sim_m1_gnt", {31'd0, m1_if.gnt}, 32'd0);
    check_val("sim_s_adr0", s_if.adr,           32'h0000_0010);
    step();
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(); #1;
    check_val("ho_m1_gnt",  {31'd0, m1_if.gnt}, 32'd1);
    check_val("ho_m0_gnt",  {31'd0, m0_if.gnt}, 32'd0);
    check_val("ho_s_adr1",  s_if.adr,           32'h0000_0020);
    check_val("ho_s_stb",   {31'd0, s_if.stb},  32'd1);
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(); #1;
    check_val("ho_idle_m1", {31'd0, m1_if.gnt}, 32'd0);
    $display("txn simultaneous request m0 then m1");

    // ---------------- single master 0 write ----------------
    set_m0(1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    step(); #1;
    check_val("wr_s_adr",  s_if.adr,            32'h0000_0100);
    check_val("wr_s_dat",  s_if.wdat,           32'hDEAD_BEEF);
    check_val("wr_s_we",   {31'd0, s_if.we},    32'd1);
    check_val("wr_ack_c1", {31'd0, m0_if.ack},  32'd0);
    step();
    s_if.ack = 1'b1; #1;
    check_val("wr_ack_c2", {31'd0, m0_if.ack},  32'd1);
    check_val("wr_m1_ack", {31'd0, m1_if.ack},  32'd0);
    step();
    s_if.ack = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    check_val("wr_ack_c3", {31'd0, m0_if.ack},  32'd0);
    step(); #1;
    check_val("wr_idle",   {31'd0, s_if.cyc},   32'd0);
    $display("txn m0 write adr=0x100 dat=0xdeadbeef");

    // ---------------- watchdog abort on master 1 ----------------
    set_m1(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    for (int j = 1; j <= 8; j++) begin
      step();
      if (j == 2) set_m0(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
      #1;
      check_val($sformatf("wd_stb_c%0d", j), {31'd0, s_if.stb},  32'd1);
      check_val($sformatf("wd_err_c%0d", j), {31'd0, m1_if.err}, (j == 8) ? 32'd1 : 32'd0);
    end
    step(); #1;
    check_val("wd_ab_stb",  {31'd0, s_if.stb},  32'd0);
    check_val("wd_ab_cyc",  {31'd0, s_if.cyc},  32'd0);
    check_val("wd_ab_err",  {31'd0, m1_if.err}, 32'd0);
    check_val("wd_ab_gnt1", {31'd0, m1_if.gnt}, 32'd1);
    check_val("wd_ab_gnt0", {31'd0, m0_if.gnt}, 32'd0);
    step(); #1;
    check_val("wd_ab_hold", {31'd0, m1_if.gnt}, 32'd1);
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(); #1;
    check_val("wd_m0_gnt",  {31'd0, m0_if.gnt}, 32'd1);
    check_val("wd_m1_rel",  {31'd0, m1_if.gnt}, 32'd0);
    check_val("wd_m0_adr",  s_if.adr,           32'h0000_0300);
    s_if.ack = 1'b1; #1;
    check_val("wd_m0_ack",  {31'd0, m0_if.ack}, 32'd1);
    step();
    s_if.ack = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    $display("txn m1 watchdog abort, m0 served after");

    // ---------------- ack on the watchdog cycle ----------------
    set_m0(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
    for (int j = 1; j <= 8; j++) begin
      step();
      if (j == 8) s_if.ack = 1'b1;
      #1;
      check_val($sformatf("wa_err_c%0d", j), {31'd0, m0_if.err}, 32'd0);
      check_val($sformatf("wa_ack_c%0d", j), {31'd0, m0_if.ack}, (j == 8) ? 32'd1 : 32'd0);
    end
    step();
    s_if.ack = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    check_val("wa_err_after", {31'd0, m0_if.err}, 32'd0);
    step(); #1;
    check_val("wa_idle",      {31'd0, m0_if.gnt}, 32'd0);
    $display("txn m0 ack on watchdog cycle");

    // ---------------- reset mid-transaction ----------------
    set_m0(1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'h1111_2222);
    step(); #1;
    check_val("mr_pre_stb", {31'd0, s_if.stb},  32'd1);
    #2;
    rst = 1'b0;
    s_if.ack = 1'b1;
    #1;
    check_val("mr_s_stb",   {31'd0, s_if.stb},  32'd0);
    check_val("mr_s_cyc",   {31'd0, s_if.cyc},  32'd0);
    check_val("mr_m0_gnt",  {31'd0, m0_if.gnt}, 32'd0);
    check_val("mr_m0_ack",  {31'd0, m0_if.ack}, 32'd0);
    check_val("mr_m0_err",  {31'd0, m0_if.err}, 32'd0);
    check_val("mr_s_adr",   s_if.adr,           32'd0);
    s_if.ack = 1'b0;
    step();
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    rst = 1'b1;
    $display("txn reset mid-transaction");

    // ---------------- round robin, 4 reads each ----------------
    rem[0] = 4; rem[1] = 4;
    acks[0] = 0; acks[1] = 0;
    step();
    set_m0(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
    set_m1(1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0);
    for (int i = 0; i < 8; i++) begin
      int own;
      int prv;
      logic og, ng, oa, na;
      logic [31:0] od;
      own = i % 2;
      prv = 1 - own;
      step();
      if (i > 0 && rem[prv] > 0) begin
        if (prv == 0) set_m0(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
        else          set_m1(1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0);
      end
      s_if.ack  = 1'b1;
      s_if.rdat = 32'h1234_5678;
      #1;
      og = (own == 0) ? m0_if.gnt : m1_if.gnt;
      ng = (own == 0) ? m1_if.gnt : m0_if.gnt;
      oa = (own == 0) ? m0_if.ack : m1_if.ack;
      na = (own == 0) ? m1_if.ack : m0_if.ack;
      od = (own == 0) ? m0_if.rdat : m1_if.rdat;
      if (oa) acks[own]++;
      check_val($sformatf("rr%0d_gnt_own", i), {31'd0, og}, 32'd1);
      check_val($sformatf("rr%0d_gnt_oth", i), {31'd0, ng}, 32'd0);
      check_val($sformatf("rr%0d_ack_oth", i), {31'd0, na}, 32'd0);
      check_val($sformatf("rr%0d_dat",     i), od,          32'h1234_5678);
      $display("txn rr read %0d granted m%0d", i, own);
      step();
      s_if.ack  = 1'b0;
      s_if.rdat = 32'h0;
      if (own == 0) set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      else          set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      rem[own]--;
    end
    check_val("rr_acks_m0", acks[0], 32'd4);
    check_val("rr_acks_m1", acks[1], 32'd4);
    step(); #1;
    check_val("rr_end_g0", {31'd0, m0_if.gnt}, 32'd0);
    check_val("rr_end_g1", {31'd0, m1_if.gnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
